// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT datapath blocks.
//   NTT_W_DEFAULT : default coefficient/modulus width in bits
//   OP_ADD/OP_SUB : encoding of the add/subtract select carried with each request
package ntt_pkg;

  localparam int unsigned NTT_W_DEFAULT = 48;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_reduce_once.sv
// Single conditional correction step of a modular add/subtract.
// Takes the raw W+1-bit sum or difference of two residues and brings it back into [0, q).
// Ports:
//   raw : W+1-bit raw a+b (add) or a-b (sub, bit W is the borrow)
//   q   : modulus
//   op  : OP_ADD / OP_SUB
//   r   : corrected W-bit result
// Purely combinational.
module mod_reduce_once
  import ntt_pkg::*;
#(
  parameter int unsigned W = NTT_W_DEFAULT
) (
  input  logic [W:0]   raw,
  input  logic [W-1:0] q,
  input  logic         op,
  output logic [W-1:0] r
);

  logic [W:0]   q_ext;
  logic [W-1:0] raw_lo;
  logic [W-1:0] raw_minus_q;
  logic [W-1:0] raw_plus_q;

  assign q_ext  = {1'b0, q};
  assign raw_lo = raw[W-1:0];

  // Both corrections are done in W bits: whenever a correction is selected, the true result
  // lies in [0, q) and so fits in W bits, making wrap-around arithmetic exact.
  assign raw_minus_q = raw_lo - q;
  assign raw_plus_q  = raw_lo + q;

  always_comb begin
    r = raw_lo;
    if (op == OP_SUB) begin
      // Borrow out of a-b means the difference went negative: add q back.
      if (raw[W]) begin
        r = raw_plus_q;
      end
    end else begin
      // >= so that a+b == q folds to 0, never q.
      if (raw >= q_ext) begin
        r = raw_minus_q;
      end
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Pipelined modular adder/subtractor with valid/ready handshake and full backpressure.
// Computes (a+b) mod q or (a-b) mod q per transaction and returns the request tag with it.
// Ports:
//   clk, rstn            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : request handshake; in_ready is combinational from out_ready
//   in_op                : OP_ADD / OP_SUB
//   in_a, in_b, in_q     : operands (< q) and modulus (>= 2), all W bits
//   in_tag               : opaque tag returned with the result
//   out_valid / out_ready: result handshake
//   out_r, out_tag       : result in [0, q) and its tag; held stable while stalled
// Stages: S1 (request register) -> [S2 raw sum/diff, MID_REG=1 only] -> output register.
// Latency accept->out_valid is 2 cycles, or 3 with MID_REG=1. Each stage advances when it
// holds data and the next stage is empty or itself advancing, so bubbles collapse.
module mod_addsub_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned W       = NTT_W_DEFAULT,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned MID_REG = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_q,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_r,
  output logic [TAG_W-1:0] out_tag
);

  // ---------------------------------------------------------------------------------------
  // Handshake signals common to both pipeline depths
  // ---------------------------------------------------------------------------------------
  logic in_accept;   // request enters S1 this cycle
  logic s1_adv;      // S1 contents move to the next stage this cycle
  logic tail_valid;  // valid bit of the stage feeding the output register
  logic tail_ready;  // output register can take a new result this cycle
  logic tail_adv;    // output register loads this cycle

  // ---------------------------------------------------------------------------------------
  // S1: request register
  // ---------------------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic             s1_op_q;
  logic [W-1:0]     s1_a_q;
  logic [W-1:0]     s1_b_q;
  logic [W-1:0]     s1_q_q;
  logic [TAG_W-1:0] s1_tag_q;

  assign in_ready  = ~s1_valid_q | s1_adv;
  assign in_accept = in_valid & in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_q_q     <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_accept) begin
        s1_op_q  <= in_op;
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_q_q   <= in_q;
        s1_tag_q <= in_tag;
      end
    end
  end

  // Raw sum or difference in W+1 bits; for subtract, bit W is the borrow.
  logic [W:0] s1_raw;

  always_comb begin
    if (s1_op_q == OP_SUB) begin
      s1_raw = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    end else begin
      s1_raw = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    end
  end

  // ---------------------------------------------------------------------------------------
  // Optional S2 between raw add/sub and correction
  // ---------------------------------------------------------------------------------------
  logic [W:0]       tail_raw;
  logic [W-1:0]     tail_q;
  logic             tail_op;
  logic [TAG_W-1:0] tail_tag;

  if (MID_REG != 0) begin : g_mid
    logic             s2_valid_q, s2_valid_d;
    logic [W:0]       s2_raw_q;
    logic [W-1:0]     s2_q_q;
    logic             s2_op_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic             s2_ready;

    assign s2_ready = ~s2_valid_q | tail_adv;
    assign s1_adv   = s1_valid_q & s2_ready;

    always_comb begin
      s2_valid_d = s2_valid_q;
      if (s1_adv) begin
        s2_valid_d = 1'b1;
      end else if (tail_adv) begin
        s2_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s2_valid_q <= 1'b0;
        s2_raw_q   <= '0;
        s2_q_q     <= '0;
        s2_op_q    <= OP_ADD;
        s2_tag_q   <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        if (s1_adv) begin
          s2_raw_q <= s1_raw;
          s2_q_q   <= s1_q_q;
          s2_op_q  <= s1_op_q;
          s2_tag_q <= s1_tag_q;
        end
      end
    end

    assign tail_valid = s2_valid_q;
    assign tail_raw   = s2_raw_q;
    assign tail_q     = s2_q_q;
    assign tail_op    = s2_op_q;
    assign tail_tag   = s2_tag_q;
  end else begin : g_no_mid
    assign s1_adv     = s1_valid_q & tail_ready;
    assign tail_valid = s1_valid_q;
    assign tail_raw   = s1_raw;
    assign tail_q     = s1_q_q;
    assign tail_op    = s1_op_q;
    assign tail_tag   = s1_tag_q;
  end

  // ---------------------------------------------------------------------------------------
  // Correction and output register
  // ---------------------------------------------------------------------------------------
  logic [W-1:0] tail_r;

  mod_reduce_once #(
    .W (W)
  ) u_reduce (
    .raw (tail_raw),
    .q   (tail_q),
    .op  (tail_op),
    .r   (tail_r)
  );

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_r_q;
  logic [TAG_W-1:0] out_tag_q;

  assign tail_ready = ~out_valid_q | out_ready;
  assign tail_adv   = tail_valid & tail_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (tail_adv) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      // Data only changes on a load, so it is held stable while the consumer stalls.
      if (tail_adv) begin
        out_r_q   <= tail_r;
        out_tag_q <= tail_tag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe (W=48, TAG_W=8).
module tb_mod_addsub_pipe;

  localparam int unsigned W       = 48;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned MID_REG = 0;
  localparam int          LAT     = 2 + MID_REG;

  localparam longint unsigned Q13 = 64'd12289;
  localparam longint unsigned Q48 = 64'h0000_FFFF_FFFF_FFC5;  // 2^48 - 59

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     in_q;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_r;
  logic [TAG_W-1:0] out_tag;

  mod_addsub_pipe #(
    .W       (W),
    .TAG_W   (TAG_W),
    .MID_REG (MID_REG)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_q      (in_q),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned r;
    longint unsigned tag;
    bit              has_lit;
    longint unsigned lit;
    int              cyc;
  } exp_t;

  exp_t            exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              cyc   = 0;
  bit              chk_lat = 1'b1;
  bit              cur_has_lit = 1'b0;
  longint unsigned cur_lit = 0;
  bit              hold_prev = 1'b0;
  longint unsigned prev_r = 0;
  longint unsigned prev_tag = 0;

  // Reference: the modular result straight from its definition.
  function automatic longint unsigned model(bit op, longint unsigned a, longint unsigned b,
                                            longint unsigned q);
    longint unsigned s;
    if (!op) begin
      s = a + b;
      return (s >= q) ? s - q : s;
    end
    return (a >= b) ? a - b : q - (b - a);
  endfunction

  task automatic check(string name, longint unsigned act, longint unsigned req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Compare process: checks every presented result against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid) begin
        check("hold_r", out_r, prev_r);
        check("hold_tag", out_tag, prev_tag);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: got out_valid=1 r=%0d, expected no result, cycle %0d",
                   out_r, cyc);
        end else begin
          check("out_r", out_r, exp_q[0].r);
          check("out_tag", out_tag, exp_q[0].tag);
          if (exp_q[0].has_lit) check("out_r_literal", out_r, exp_q[0].lit);
          if (out_ready) begin
            if (chk_lat) check("latency", longint'(cyc - exp_q[0].cyc), longint'(LAT));
            void'(exp_q.pop_front());
          end
        end
      end
      hold_prev = out_valid & ~out_ready;
      prev_r    = out_r;
      prev_tag  = out_tag;
      if (in_valid && in_ready) begin
        exp_q.push_back('{r: model(in_op, in_a, in_b, in_q), tag: in_tag,
                          has_lit: cur_has_lit, lit: cur_lit, cyc: cyc});
      end
    end
  end

  task automatic send(bit op, longint unsigned a, longint unsigned b, longint unsigned q,
                      int tag, bit has_lit, longint unsigned lit);
    bit acc;
    acc = 1'b0;
    if (has_lit) check("model_literal", model(op, a, b, q), lit);
    in_valid    = 1'b1;
    in_op       = op;
    in_a        = a[W-1:0];
    in_b        = b[W-1:0];
    in_q        = q[W-1:0];
    in_tag      = tag[TAG_W-1:0];
    cur_has_lit = has_lit;
    cur_lit     = lit;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", acc, 1);
    in_valid    = 1'b0;
    cur_has_lit = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_cnt;
    longint unsigned qq, a, b;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_q      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_tag", out_tag, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // 1-3: directed vectors with hand-computed results
    send(0, 5, 7, Q13, 8'h11, 1, 12);
    send(0, 12288, 1, Q13, 8'h22, 1, 0);
    send(0, 12288, 12288, Q13, 8'h33, 1, 12287);
    send(1, 3, 5, Q13, 8'h44, 1, 12287);
    send(1, 0, 0, Q13, 8'h55, 1, 0);
    send(1, 12288, 0, Q13, 8'h66, 1, 12288);
    send(1, 7, 7, Q13, 8'h77, 1, 0);
    send(0, Q48 - 1, Q48 - 1, Q48, 8'h88, 1, 64'h0000_FFFF_FFFF_FFC3);
    send(1, 0, Q48 - 1, Q48, 8'h99, 1, 1);
    drain();

    // 4: back-to-back random traffic at full rate
    for (int i = 0; i < 100; i++) begin
      qq = (i % 2 == 0) ? Q13 : Q48;
      a  = {$urandom(), $urandom()} % qq;
      b  = {$urandom(), $urandom()} % qq;
      send($urandom_range(0, 1), a, b, qq, i, 0, 0);
    end
    drain();

    // 5: stall the output with in_valid held high
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    acc_cnt   = 0;
    in_valid  = 1'b1;
    in_op     = 1'b0;
    in_q      = Q13[W-1:0];
    in_a      = 48'd100;
    in_b      = 48'd0;
    in_tag    = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) acc_cnt++;
      @(posedge clk);
      #1;
      in_tag = acc_cnt[TAG_W-1:0];
      in_a   = 48'd100 + acc_cnt;
    end
    check("stall_accepts", acc_cnt, LAT);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_head_tag", out_tag, 0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = acc_cnt; t < 6; t++) send(0, 100 + t, 0, Q13, t, 1, 100 + t);
    drain();

    // 6: reset with transactions in flight
    out_ready = 1'b0;
    send(0, 1, 2, Q13, 8'hA1, 0, 0);
    send(0, 3, 4, Q13, 8'hA2, 0, 0);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_r", out_r, 0);
    repeat (2) @(posedge clk);
    #3;
    rstn      = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send(1, 10, 4, Q13, 8'hB7, 1, 6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
